unidade_controle: RTL and testbench

// - Fetch/decode/sequence stage directly upstream of the ULA and data RAM in

---
 rtl/unidade_controle_pkg.sv | 33 +++
 rtl/unidade_controle_memoria_programa.sv | 35 +++
 rtl/unidade_controle.sv | 127 ++++++++++++
 tb/tb_unidade_controle.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/unidade_controle_pkg.sv
// Shared definitions for the processadorSimples control unit.
//
// Contents:
//   state_t        - FSM state encoding (S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_HALT)
//   OP_*           - opcode constants, including the ALU opcode range
//   drives_ula()   - opcodes whose EXECUTE step pulses ula_enable
package unidade_controle_pkg;

    localparam int OPCODE_W = 4;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_EXEC   = 3'd3,
        S_HALT   = 3'd4
    } state_t;

    localparam logic [OPCODE_W-1:0] OP_NOP       = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_ALU_FIRST = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_ALU_LAST  = 4'h7;
    localparam logic [OPCODE_W-1:0] OP_LOAD      = 4'h8;
    localparam logic [OPCODE_W-1:0] OP_STORE     = 4'h9;
    localparam logic [OPCODE_W-1:0] OP_JMP       = 4'hA;
    localparam logic [OPCODE_W-1:0] OP_JZ        = 4'hB;
    localparam logic [OPCODE_W-1:0] OP_HALT      = 4'hF;

    // LOAD goes through the ULA as well: the ULA owns the RAM-to-register move.
    function automatic logic drives_ula(input logic [OPCODE_W-1:0] op);
        return ((op >= OP_ALU_FIRST) && (op <= OP_ALU_LAST)) || (op == OP_LOAD);
    endfunction

endpackage

// File: rtl/unidade_controle_memoria_programa.sv
// Program memory for the control unit.
//
// 2**ADDR_W x INSTR_W array, synchronous write, combinational read, no reset
// (contents survive reset_n so a loaded program can be re-run).
//
// Ports:
//   clock  - write clock
//   we     - write strobe (already qualified by the FSM)
//   waddr  - write address
//   wdata  - write data
//   raddr  - read address (the program counter)
//   rdata  - instruction at raddr
module memoria_programa #(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 8
) (
    input  logic               clock,
    input  logic               we,
    input  logic [ADDR_W-1:0]  waddr,
    input  logic [INSTR_W-1:0] wdata,
    input  logic [ADDR_W-1:0]  raddr,
    output logic [INSTR_W-1:0] rdata
);

    logic [INSTR_W-1:0] mem [2**ADDR_W];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/unidade_controle.sv
// Control unit of processadorSimples: fetches 8-bit instructions from a small
// program memory, decodes them into opcode/endereco for the ULA and data RAM,
// and pulses the ULA enable / RAM write strobes.
//
// Ports:
//   clock, reset_n      - system clock (rising edge), async active-low reset
//   run                 - start/resume pulse, honoured only in IDLE or HALT
//   step_mode           - 1: return to IDLE after each instruction
//   prog_we/addr/data   - program load port, honoured only in IDLE or HALT
//   ula_zero            - ULA zero flag, sampled in EXECUTE (for JZ)
//   opcode, endereco    - registered decoded fields to ULA / RAM
//   ula_enable, ram_we  - single-cycle strobes
//   pc                  - program counter
//   halted              - high while in HALT
//   state               - current FSM state (debug visibility)
//
// Handshake: run and prog_we are plain level inputs sampled on the rising
// edge; they have effect only when state is IDLE or HALT and are dropped
// silently otherwise. ula_enable/ram_we are one-cycle strobes registered on
// the EXEC edge, so each is presented in the cycle right after S_EXEC while
// opcode/endereco still carry the instruction that produced it. They are
// mutually exclusive.
module unidade_controle
    import unidade_controle_pkg::*;
#(
    parameter int ADDR_W  = 4,
    parameter int INSTR_W = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                run,
    input  logic                step_mode,
    input  logic                prog_we,
    input  logic [ADDR_W-1:0]   prog_addr,
    input  logic [INSTR_W-1:0]  prog_data,
    input  logic                ula_zero,
    output logic [OPCODE_W-1:0] opcode,
    output logic [ADDR_W-1:0]   endereco,
    output logic                ula_enable,
    output logic                ram_we,
    output logic [ADDR_W-1:0]   pc,
    output logic                halted,
    output state_t              state
);

    localparam logic [ADDR_W-1:0] PC_ONE = ADDR_W'(1);

    logic [INSTR_W-1:0] ir;
    logic [INSTR_W-1:0] instr;
    logic               prog_ok;

    // Loading the program while the FSM is walking it would race the fetch.
    assign prog_ok = (state == S_IDLE) || (state == S_HALT);

    memoria_programa #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W)
    ) u_memoria (
        .clock (clock),
        .we    (prog_we && prog_ok),
        .waddr (prog_addr),
        .wdata (prog_data),
        .raddr (pc),
        .rdata (instr)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= S_IDLE;
            pc         <= '0;
            ir         <= '0;
            opcode     <= '0;
            endereco   <= '0;
            ula_enable <= 1'b0;
            ram_we     <= 1'b0;
            halted     <= 1'b0;
        end else begin
            // Strobes default low so each lasts exactly one cycle.
            ula_enable <= 1'b0;
            ram_we     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (run) begin
                        state <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    ir    <= instr;
                    pc    <= pc + PC_ONE;   // wraps naturally at 2**ADDR_W
                    state <= S_DECODE;
                end
                S_DECODE: begin
                    opcode   <= ir[OPCODE_W-1:0];
                    endereco <= ir[INSTR_W-1:OPCODE_W];
                    state    <= S_EXEC;
                end
                S_EXEC: begin
                    ula_enable <= drives_ula(opcode);
                    ram_we     <= (opcode == OP_STORE);
                    // Jump target replaces the already-incremented pc.
                    if ((opcode == OP_JMP) || ((opcode == OP_JZ) && ula_zero)) begin
                        pc <= endereco;
                    end
                    if (opcode == OP_HALT) begin
                        state  <= S_HALT;
                        halted <= 1'b1;
                    end else if (step_mode) begin
                        state <= S_IDLE;
                    end else begin
                        state <= S_FETCH;
                    end
                end
                S_HALT: begin
                    if (run) begin
                        pc     <= '0;
                        halted <= 1'b0;
                        state  <= S_FETCH;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_unidade_controle.sv
module tb_unidade_controle;
    import unidade_controle_pkg::*;

    localparam logic [1:0] K_ULA = 2'b01;
    localparam logic [1:0] K_RAM = 2'b10;

    logic       clock;
    logic       reset_n;
    logic       run;
    logic       step_mode;
    logic       prog_we;
    logic [3:0] prog_addr;
    logic [7:0] prog_data;
    logic       ula_zero;
    logic [3:0] opcode;
    logic [3:0] endereco;
    logic       ula_enable;
    logic       ram_we;
    logic [3:0] pc;
    logic       halted;
    state_t     state;

    // Scoreboard: {kind, opcode, endereco} of every strobe expected, in order.
    logic [9:0] exp_q[$];
    int checks = 0;
    int passes = 0;
    int fails  = 0;
    logic [3:0] ops [16];

    unidade_controle dut (
        .clock      (clock),
        .reset_n    (reset_n),
        .run        (run),
        .step_mode  (step_mode),
        .prog_we    (prog_we),
        .prog_addr  (prog_addr),
        .prog_data  (prog_data),
        .ula_zero   (ula_zero),
        .opcode     (opcode),
        .endereco   (endereco),
        .ula_enable (ula_enable),
        .ram_we     (ram_we),
        .pc         (pc),
        .halted     (halted),
        .state      (state)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Runs once per cycle, after the edge: strobe exclusivity and scoreboard pop.
    task automatic mon();
        logic [9:0] got;
        logic [9:0] exp;
        chk("strobe_exclusive", {31'b0, ula_enable & ram_we}, 32'd0);
        if (ula_enable || ram_we) begin
            got = {ram_we, ula_enable, opcode, endereco};
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", {22'b0, got}, 32'd0);
            end else begin
                exp = exp_q.pop_front();
                chk("strobe_event", {22'b0, got}, {22'b0, exp});
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick_mon();
        @(posedge clock);
        #1;
        mon();
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        run     = 1'b0;
        prog_we = 1'b0;
        @(posedge clock);
        @(posedge clock);
        #1;
        chk("rst_state", {29'b0, state}, {29'b0, S_IDLE});
        chk("rst_pc", {28'b0, pc}, 32'd0);
        chk("rst_opcode", {28'b0, opcode}, 32'd0);
        chk("rst_endereco", {28'b0, endereco}, 32'd0);
        chk("rst_strobes", {30'b0, ula_enable, ram_we}, 32'd0);
        chk("rst_halted", {31'b0, halted}, 32'd0);
        exp_q.delete();
        reset_n = 1'b1;
    endtask

    task automatic prog_write(input logic [3:0] a, input logic [7:0] d);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        tick_mon();
        prog_we   = 1'b0;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        tick_mon();
        run = 1'b0;
    endtask

    task automatic push_ev(input logic [1:0] k, input logic [3:0] op, input logic [3:0] en);
        exp_q.push_back({k, op, en});
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        reset_n   = 1'b0;
        run       = 1'b0;
        step_mode = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        ula_zero  = 1'b0;
        do_reset();

        // Free-run: ALU, STORE, HALT with cycle-exact timing (cycle 1 = run edge).
        prog_write(4'd0, 8'h31);
        prog_write(4'd1, 8'h59);
        prog_write(4'd2, 8'h0F);
        push_ev(K_ULA, 4'h1, 4'h3);
        push_ev(K_RAM, 4'h9, 4'h5);
        pulse_run();
        for (int c = 2; c <= 12; c++) begin
            tick_mon();
            if (c == 4) begin
                chk("fr_ula_c4", {31'b0, ula_enable}, 32'd1);
                chk("fr_opcode_c4", {28'b0, opcode}, 32'h1);
                chk("fr_endereco_c4", {28'b0, endereco}, 32'h3);
            end
            if (c == 7) begin
                chk("fr_ram_c7", {31'b0, ram_we}, 32'd1);
                chk("fr_endereco_c7", {28'b0, endereco}, 32'h5);
            end
            if (c == 9) chk("fr_halted_c9", {31'b0, halted}, 32'd0);
            if (c >= 10) begin
                chk("fr_halted", {31'b0, halted}, 32'd1);
                chk("fr_pc", {28'b0, pc}, 32'd3);
            end
        end
        chk("fr_halt_state", {29'b0, state}, {29'b0, S_HALT});
        chk("fr_hold_opcode", {28'b0, opcode}, 32'hF);
        chk("fr_sb_empty", exp_q.size(), 32'd0);

        // JMP: [0] jumps to 4, [4] halts -> pc 5. Program written while in HALT.
        prog_write(4'd0, 8'h4A);
        prog_write(4'd4, 8'h0F);
        pulse_run();
        repeat (9) tick_mon();
        chk("jmp_halted", {31'b0, halted}, 32'd1);
        chk("jmp_pc", {28'b0, pc}, 32'd5);

        // JZ to 5: not taken with ula_zero=0, taken with ula_zero=1.
        prog_write(4'd0, 8'h5B);
        prog_write(4'd1, 8'h0F);
        prog_write(4'd5, 8'h0F);
        ula_zero = 1'b0;
        pulse_run();
        repeat (9) tick_mon();
        chk("jz0_halted", {31'b0, halted}, 32'd1);
        chk("jz0_pc", {28'b0, pc}, 32'd2);
        ula_zero = 1'b1;
        pulse_run();
        repeat (9) tick_mon();
        chk("jz1_halted", {31'b0, halted}, 32'd1);
        chk("jz1_pc", {28'b0, pc}, 32'd6);
        ula_zero = 1'b0;

        // JMP to self loops forever without halting.
        prog_write(4'd0, 8'h0A);
        pulse_run();
        repeat (30) tick_mon();
        chk("self_loop_halted", {31'b0, halted}, 32'd0);
        chk("self_loop_pc_low", {28'b0, pc & 4'hE}, 32'd0);
        chk("self_loop_sb_empty", exp_q.size(), 32'd0);

        // Step mode: one instruction per run pulse.
        do_reset();
        step_mode = 1'b1;
        prog_write(4'd0, 8'h31);
        prog_write(4'd1, 8'h28);
        prog_write(4'd2, 8'h69);
        push_ev(K_ULA, 4'h1, 4'h3);
        push_ev(K_ULA, 4'h8, 4'h2);
        push_ev(K_RAM, 4'h9, 4'h6);
        for (int k = 0; k < 3; k++) begin
            pulse_run();
            repeat (5) tick_mon();
            chk("step_idle", {29'b0, state}, {29'b0, S_IDLE});
            chk("step_pc", {28'b0, pc}, k + 1);
            chk("step_sb_left", exp_q.size(), 2 - k);
        end
        step_mode = 1'b0;

        // Write lockout: writes to [1] during FETCH/DECODE are dropped.
        do_reset();
        prog_write(4'd0, 8'h00);
        prog_write(4'd1, 8'h0F);
        run = 1'b1;
        tick_mon();
        run       = 1'b0;
        prog_we   = 1'b1;
        prog_addr = 4'd1;
        prog_data = 8'h72;
        tick_mon();
        tick_mon();
        prog_we = 1'b0;
        repeat (5) tick_mon();
        chk("lock_halted", {31'b0, halted}, 32'd1);
        chk("lock_pc", {28'b0, pc}, 32'd2);
        chk("lock_sb_empty", exp_q.size(), 32'd0);

        // IDLE writes land; a write in the same cycle as run is seen by FETCH.
        do_reset();
        prog_write(4'd1, 8'h72);
        prog_write(4'd2, 8'h0F);
        push_ev(K_ULA, 4'h8, 4'h8);
        push_ev(K_ULA, 4'h2, 4'h7);
        prog_we   = 1'b1;
        prog_addr = 4'd0;
        prog_data = 8'h88;
        run       = 1'b1;
        tick_mon();
        prog_we = 1'b0;
        run     = 1'b0;
        repeat (9) tick_mon();
        chk("idlewr_halted", {31'b0, halted}, 32'd1);
        chk("idlewr_pc", {28'b0, pc}, 32'd3);
        chk("idlewr_sb_empty", exp_q.size(), 32'd0);

        // Wrap: 16 instructions, no HALT; run mid-flight ignored.
        do_reset();
        for (int i = 0; i < 16; i++) begin
            ops[i] = 4'($urandom_range(1, 7));
            prog_write(4'(i), {4'(i), ops[i]});
        end
        for (int k = 0; k < 20; k++) begin
            push_ev(K_ULA, ops[k % 16], 4'(k % 16));
        end
        pulse_run();
        for (int c = 2; c <= 61; c++) begin
            run = (c == 21);
            tick_mon();
        end
        run = 1'b0;
        chk("wrap_pc", {28'b0, pc}, 32'd4);
        chk("wrap_state", {29'b0, state}, {29'b0, S_FETCH});
        chk("wrap_halted", {31'b0, halted}, 32'd0);
        chk("wrap_sb_empty", exp_q.size(), 32'd0);

        // Reset in the middle of a STORE strobe.
        do_reset();
        prog_write(4'd0, 8'h59);
        push_ev(K_RAM, 4'h9, 4'h5);
        pulse_run();
        repeat (3) tick_mon();
        chk("midrst_ram_before", {31'b0, ram_we}, 32'd1);
        reset_n = 1'b0;
        #1;
        chk("midrst_ram_we", {31'b0, ram_we}, 32'd0);
        chk("midrst_ula", {31'b0, ula_enable}, 32'd0);
        chk("midrst_pc", {28'b0, pc}, 32'd0);
        chk("midrst_halted", {31'b0, halted}, 32'd0);
        chk("midrst_state", {29'b0, state}, {29'b0, S_IDLE});
        @(posedge clock);
        #1;
        reset_n = 1'b1;
        repeat (3) tick_mon();
        chk("final_sb_empty", exp_q.size(), 32'd0);

        // ---------------- final report ----------------
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
